// File: rtl/rv_opfetch_stage.sv
// Operand-fetch/issue stage: one entry register between decode and ALU2. Operands resolve through a
// priority bypass network, and the stage stalls while a matching producer's result is still pending.
module rv_opfetch_stage #(
  parameter int XLEN   = 32,
  parameter int NBP    = 4,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_flush,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [4:0]           i_rs1,
  input  logic [4:0]           i_rs2,
  input  logic [4:0]           i_rd,
  input  logic [XLEN-1:0]      i_reg1_data,
  input  logic [XLEN-1:0]      i_reg2_data,
  input  logic [XLEN-1:0]      i_pc,
  input  logic [XLEN-1:0]      i_imm,
  input  logic                 i_op1_pc,
  input  logic                 i_op2_imm,
  input  logic [CTRL_W-1:0]    i_ctrl,
  input  logic [NBP-1:0]       i_bp_valid,
  input  logic [NBP-1:0]       i_bp_ready,
  input  logic [5*NBP-1:0]     i_bp_rd,
  input  logic [XLEN*NBP-1:0]  i_bp_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [XLEN-1:0]      o_op1,
  output logic [XLEN-1:0]      o_op2,
  output logic [XLEN-1:0]      o_rs2_data,
  output logic [XLEN-1:0]      o_rs1_data,
  output logic [XLEN-1:0]      o_pc,
  output logic [XLEN-1:0]      o_imm,
  output logic [4:0]           o_rd,
  output logic [CTRL_W-1:0]    o_ctrl,
  output logic [CNT_W-1:0]     o_stall_cnt
);

  logic              full_q;
  logic [4:0]        rs1_q, rs2_q, rd_q;
  logic [XLEN-1:0]   pc_q, imm_q, d1_q, d2_q;
  logic              op1_pc_q, op2_imm_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [CNT_W-1:0]  stall_cnt_q;

  logic              m1, m2, r1, r2;
  logic [XLEN-1:0]   b1, b2;
  logic              hazard1, hazard2;
  logic [XLEN-1:0]   val1, val2;
  logic              consume, load, stall_inc;

  // Priority match: scan youngest-last so the lowest index overwrites older matches.
  always_comb begin
    m1 = 1'b0;
    r1 = 1'b0;
    b1 = '0;
    m2 = 1'b0;
    r2 = 1'b0;
    b2 = '0;
    for (int n = NBP - 1; n >= 0; n--) begin
      if (i_bp_valid[n] && (i_bp_rd[5*n +: 5] == rs1_q)) begin
        m1 = 1'b1;
        r1 = i_bp_ready[n];
        b1 = i_bp_data[XLEN*n +: XLEN];
      end
      if (i_bp_valid[n] && (i_bp_rd[5*n +: 5] == rs2_q)) begin
        m2 = 1'b1;
        r2 = i_bp_ready[n];
        b2 = i_bp_data[XLEN*n +: XLEN];
      end
    end
  end

  assign hazard1 = (rs1_q != 5'd0) && m1 && !r1;
  assign hazard2 = (rs2_q != 5'd0) && m2 && !r2;
  assign val1    = (rs1_q == 5'd0) ? '0 : ((m1 && r1) ? b1 : d1_q);
  assign val2    = (rs2_q == 5'd0) ? '0 : ((m2 && r2) ? b2 : d2_q);

  // Handshake: a transfer happens on a clock edge where valid and ready are both high. o_valid never
  // depends on i_ready. o_ready may depend on i_ready, so a drained entry refills in the same cycle.
  assign o_valid   = full_q && !hazard1 && !hazard2;
  assign o_ready   = !full_q || (o_valid && i_ready);
  assign consume   = o_valid && i_ready;
  assign load      = i_valid && o_ready && !i_flush;
  assign stall_inc = full_q && (hazard1 || hazard2) && !i_flush;

  assign o_op1       = op1_pc_q ? pc_q : val1;
  assign o_op2       = op2_imm_q ? imm_q : val2;
  assign o_rs1_data  = val1;
  assign o_rs2_data  = val2;
  assign o_pc        = pc_q;
  assign o_imm       = imm_q;
  assign o_rd        = rd_q;
  assign o_ctrl      = ctrl_q;
  assign o_stall_cnt = stall_cnt_q;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      full_q      <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      pc_q        <= '0;
      imm_q       <= '0;
      d1_q        <= '0;
      d2_q        <= '0;
      op1_pc_q    <= 1'b0;
      op2_imm_q   <= 1'b0;
      ctrl_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (i_flush) begin
        full_q <= 1'b0;
        rd_q   <= '0;
        ctrl_q <= '0;
      end else if (load) begin
        full_q    <= 1'b1;
        rs1_q     <= i_rs1;
        rs2_q     <= i_rs2;
        rd_q      <= i_rd;
        pc_q      <= i_pc;
        imm_q     <= i_imm;
        d1_q      <= i_reg1_data;
        d2_q      <= i_reg2_data;
        op1_pc_q  <= i_op1_pc;
        op2_imm_q <= i_op2_imm;
        ctrl_q    <= i_ctrl;
      end else if (consume) begin
        full_q <= 1'b0;
      end else if (full_q) begin
        // Capture forwarded values while held so a producer retiring past the last source is not lost.
        if (m1 && r1) d1_q <= b1;
        if (m2 && r2) d2_q <= b2;
      end
      if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rv_opfetch_stage.sv
// Self-checking bench for rv_opfetch_stage: a vector table for single-instruction resolution, plus
// hand-written sequences for stalls, refresh, flush, reset and counter saturation.
module tb_rv_opfetch_stage;
  localparam int XLEN = 32;
  localparam int NBP  = 4;
  localparam int CW   = 16;
  localparam int CNTW = 4;
  localparam int SB_W = 6*XLEN + 5 + CW;

  logic            i_clk = 1'b0;
  logic            i_reset_n, i_flush, i_valid, o_ready, i_ready, o_valid;
  logic [4:0]      i_rs1, i_rs2, i_rd, o_rd;
  logic [31:0]     i_reg1_data, i_reg2_data, i_pc, i_imm;
  logic            i_op1_pc, i_op2_imm;
  logic [CW-1:0]   i_ctrl, o_ctrl;
  logic [3:0]      i_bp_valid, i_bp_ready;
  logic [19:0]     i_bp_rd;
  logic [127:0]    i_bp_data;
  logic [31:0]     o_op1, o_op2, o_rs1_data, o_rs2_data, o_pc, o_imm;
  logic [CNTW-1:0] o_stall_cnt;

  int checks = 0;
  int failures = 0;
  logic [SB_W-1:0] exp_q[$];

  typedef struct {
    logic [4:0]   rs1, rs2, rd;
    logic [31:0]  r1, r2, pc, imm;
    logic         op1_pc, op2_imm;
    logic [15:0]  ctrl;
    logic [3:0]   bpv, bpr;
    logic [19:0]  bprd;
    logic [127:0] bpd;
    logic [31:0]  e_op1, e_op2, e_rs1, e_rs2;
  } vec_t;

  vec_t vecs[9];

  rv_opfetch_stage #(.XLEN(XLEN), .NBP(NBP), .CTRL_W(CW), .CNT_W(CNTW)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
    .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd), .i_reg1_data(i_reg1_data), .i_reg2_data(i_reg2_data),
    .i_pc(i_pc), .i_imm(i_imm), .i_op1_pc(i_op1_pc), .i_op2_imm(i_op2_imm), .i_ctrl(i_ctrl),
    .i_bp_valid(i_bp_valid), .i_bp_ready(i_bp_ready), .i_bp_rd(i_bp_rd), .i_bp_data(i_bp_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_op1(o_op1), .o_op2(o_op2), .o_rs2_data(o_rs2_data),
    .o_rs1_data(o_rs1_data), .o_pc(o_pc), .o_imm(o_imm), .o_rd(o_rd), .o_ctrl(o_ctrl),
    .o_stall_cnt(o_stall_cnt)
  );

  // Clock / reset
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    i_flush = 0; i_valid = 0; i_ready = 1;
    i_rs1 = 0; i_rs2 = 0; i_rd = 0; i_reg1_data = 0; i_reg2_data = 0;
    i_pc = 0; i_imm = 0; i_op1_pc = 0; i_op2_imm = 0; i_ctrl = 0;
    i_bp_valid = 0; i_bp_ready = 0; i_bp_rd = 0; i_bp_data = 0;
  endtask

  task automatic do_reset();
    i_reset_n = 0;
    clear_inputs();
    tick();
    i_reset_n = 1;
  endtask

  // Scoreboard
  function automatic logic [SB_W-1:0] pack_exp(logic [31:0] op1, logic [31:0] op2, logic [31:0] rs1d,
      logic [31:0] rs2d, logic [31:0] pc, logic [31:0] imm, logic [4:0] rd, logic [15:0] ctrl);
    return {op1, op2, rs1d, rs2d, pc, imm, rd, ctrl};
  endfunction

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic check_issue(string name);
    logic [SB_W-1:0] got;
    logic [SB_W-1:0] exp;
    if (o_valid && i_ready) begin
      got = {o_op1, o_op2, o_rs1_data, o_rs2_data, o_pc, o_imm, o_rd, o_ctrl};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL %s unexpected issue got=%0h", name, got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          failures++;
          $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
      end
    end
  endtask

  // Driver
  function automatic vec_t mk(logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd, logic [31:0] r1,
      logic [31:0] r2, logic [31:0] pc, logic [31:0] imm, logic op1_pc, logic op2_imm,
      logic [15:0] ctrl, logic [3:0] bpv, logic [3:0] bpr, logic [19:0] bprd, logic [127:0] bpd,
      logic [31:0] e_op1, logic [31:0] e_op2, logic [31:0] e_rs1, logic [31:0] e_rs2);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.r1 = r1; v.r2 = r2; v.pc = pc; v.imm = imm;
    v.op1_pc = op1_pc; v.op2_imm = op2_imm; v.ctrl = ctrl; v.bpv = bpv; v.bpr = bpr;
    v.bprd = bprd; v.bpd = bpd; v.e_op1 = e_op1; v.e_op2 = e_op2; v.e_rs1 = e_rs1; v.e_rs2 = e_rs2;
    return v;
  endfunction

  task automatic drive_instr(logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd, logic [31:0] r1,
      logic [31:0] r2, logic [31:0] pc, logic [31:0] imm, logic op1_pc, logic op2_imm,
      logic [15:0] ctrl);
    i_rs1 = rs1; i_rs2 = rs2; i_rd = rd; i_reg1_data = r1; i_reg2_data = r2;
    i_pc = pc; i_imm = imm; i_op1_pc = op1_pc; i_op2_imm = op2_imm; i_ctrl = ctrl;
  endtask

  task automatic drive_bp(logic [3:0] v, logic [3:0] r, logic [19:0] rd, logic [127:0] d);
    i_bp_valid = v; i_bp_ready = r; i_bp_rd = rd; i_bp_data = d;
  endtask

  // Loads an entry with rs1=5 waiting on a pending load in bypass source 1.
  task automatic load_stall(logic [4:0] rd, logic [15:0] ctrl);
    drive_instr(5, 0, rd, 32'h999, 0, 32'h200, 0, 0, 0, ctrl);
    drive_bp(4'b0010, 4'b0000, {5'd0, 5'd0, 5'd5, 5'd0}, '0);
    i_valid = 1;
    tick();
    i_valid = 0;
  endtask

  initial begin
    vecs[0] = mk(1, 2, 3, 32'h100, 32'h200, 32'h1000, 32'h4, 0, 0, 16'h0001, 4'h0, 4'h0, 20'h0, '0,
                 32'h100, 32'h200, 32'h100, 32'h200);
    vecs[1] = mk(1, 2, 5, 32'h100, 32'h200, 32'h8000_0000, 32'h44, 1, 1, 16'h0002, 4'h0, 4'h0, 20'h0, '0,
                 32'h8000_0000, 32'h44, 32'h100, 32'h200);
    vecs[2] = mk(0, 0, 7, 32'hAAAA, 32'hBBBB, 32'h10, 32'h20, 0, 0, 16'h0003, 4'hF, 4'hF, 20'h0,
                 {4{32'h5}}, 0, 0, 0, 0);
    vecs[3] = mk(3, 4, 8, 32'h3333, 32'h4444, 32'h14, 0, 0, 0, 16'h0004, 4'hF, 4'hF,
                 {5'd4, 5'd3, 5'd4, 5'd3}, {32'h33, 32'h22, 32'h11, 32'h10},
                 32'h10, 32'h11, 32'h10, 32'h11);
    vecs[4] = mk(3, 4, 9, 32'h3333, 32'h4444, 32'h18, 0, 0, 0, 16'h0005, 4'b1100, 4'hF,
                 {5'd4, 5'd3, 5'd4, 5'd3}, {32'h33, 32'h22, 32'h11, 32'h10},
                 32'h22, 32'h33, 32'h22, 32'h33);
    vecs[5] = mk(3, 4, 10, 32'h3333, 32'h4444, 32'h1C, 0, 0, 0, 16'h0006, 4'hF, 4'hF,
                 {5'd9, 5'd9, 5'd9, 5'd9}, {32'h33, 32'h22, 32'h11, 32'h10},
                 32'h3333, 32'h4444, 32'h3333, 32'h4444);
    vecs[6] = mk(1, 2, 11, 32'h7, 32'h8, 32'h20, 0, 0, 0, 16'h0007, 4'hF, 4'h0,
                 {5'd10, 5'd11, 5'd12, 5'd13}, '0, 32'h7, 32'h8, 32'h7, 32'h8);
    vecs[7] = mk(0, 6, 12, 32'h11, 32'h66, 32'h24, 32'h99, 0, 1, 16'h0008, 4'b0001, 4'h0, 20'h0, '0,
                 0, 32'h99, 0, 32'h66);
    vecs[8] = mk(7, 0, 13, 32'h1, 32'hFFFF, 32'h28, 0, 0, 0, 16'h0009, 4'b0101, 4'hF,
                 {5'd0, 5'd7, 5'd0, 5'd7}, {32'h0, 32'hB0B0, 32'h0, 32'hA0A0},
                 32'hA0A0, 0, 32'hA0A0, 0);

    i_reset_n = 0;
    clear_inputs();
    tick();
    tick();
    i_reset_n = 1;
    settle();
    chk("rst_valid", o_valid, 0);
    chk("rst_ready", o_ready, 1);
    chk("rst_cnt", o_stall_cnt, 0);
    chk("rst_rd", o_rd, 0);
    chk("rst_op1", o_op1, 0);

    // Table: load each vector, then issue it the following cycle.
    for (int k = 0; k < 9; k++) begin
      drive_instr(vecs[k].rs1, vecs[k].rs2, vecs[k].rd, vecs[k].r1, vecs[k].r2, vecs[k].pc,
                  vecs[k].imm, vecs[k].op1_pc, vecs[k].op2_imm, vecs[k].ctrl);
      drive_bp(vecs[k].bpv, vecs[k].bpr, vecs[k].bprd, vecs[k].bpd);
      i_valid = 1;
      i_ready = 1;
      settle();
      chk($sformatf("vec%0d_ready", k), o_ready, 1);
      exp_q.push_back(pack_exp(vecs[k].e_op1, vecs[k].e_op2, vecs[k].e_rs1, vecs[k].e_rs2,
                               vecs[k].pc, vecs[k].imm, vecs[k].rd, vecs[k].ctrl));
      tick();
      i_valid = 0;
      settle();
      chk($sformatf("vec%0d_valid", k), o_valid, 1);
      check_issue($sformatf("vec%0d_issue", k));
      tick();
    end
    settle();
    chk("table_drained", o_valid, 0);

    // Back-to-back dependent ADDs with zero bubble.
    do_reset();
    drive_bp(4'b0001, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd3}, {96'h0, 32'h11});
    drive_instr(1, 2, 3, 32'h1, 32'h2, 32'h100, 0, 0, 0, 16'h00A0);
    i_valid = 1;
    exp_q.push_back(pack_exp(32'h1, 32'h2, 32'h1, 32'h2, 32'h100, 0, 3, 16'h00A0));
    tick();
    drive_instr(3, 3, 4, 0, 0, 32'h104, 0, 0, 0, 16'h00A1);
    exp_q.push_back(pack_exp(32'h11, 32'h11, 32'h11, 32'h11, 32'h104, 0, 4, 16'h00A1));
    settle();
    chk("b2b_valid1", o_valid, 1);
    chk("b2b_ready1", o_ready, 1);
    check_issue("b2b_issue1");
    tick();
    i_valid = 0;
    settle();
    chk("b2b_valid2", o_valid, 1);
    check_issue("b2b_issue2");
    tick();
    chk("b2b_empty", o_valid, 0);

    // Load-use: two stall cycles, then the load result arrives on bypass 1.
    do_reset();
    load_stall(6, 16'h000C);
    settle();
    chk("lu_stall0", o_valid, 0);
    tick();
    chk("lu_stall1", o_valid, 0);
    tick();
    drive_bp(4'b0010, 4'b0010, {5'd0, 5'd0, 5'd5, 5'd0}, {32'h0, 32'h0, 32'hDEAD, 32'h0});
    exp_q.push_back(pack_exp(32'hDEAD, 0, 32'hDEAD, 0, 32'h200, 0, 6, 16'h000C));
    settle();
    chk("lu_valid", o_valid, 1);
    chk("lu_cnt", o_stall_cnt, 2);
    check_issue("lu_issue");
    tick();
    chk("lu_cnt_after", o_stall_cnt, 2);

    // Refresh: rs1 forwarded once from bp3 while rs2 stalls, then bp3 retires.
    do_reset();
    drive_instr(9, 10, 1, 32'h0, 32'h77, 32'h300, 0, 0, 0, 16'h000E);
    drive_bp(4'b1001, 4'b1000, {5'd9, 5'd0, 5'd0, 5'd10}, {32'h42, 96'h0});
    i_valid = 1;
    tick();
    i_valid = 0;
    settle();
    chk("rf_stall", o_valid, 0);
    tick();
    drive_bp(4'b0001, 4'b0000, {5'd9, 5'd0, 5'd0, 5'd10}, '0);
    tick();
    drive_bp(4'b0001, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd10}, {96'h0, 32'h55});
    exp_q.push_back(pack_exp(32'h42, 32'h55, 32'h42, 32'h55, 32'h300, 0, 1, 16'h000E));
    settle();
    chk("rf_valid", o_valid, 1);
    check_issue("rf_issue");
    tick();

    // Flush: kill a stalled entry, then refuse a presented instruction; counter is kept.
    do_reset();
    load_stall(6, 16'h1234);
    tick();
    tick();
    tick();
    chk("fl_cnt_before", o_stall_cnt, 3);
    drive_bp(4'b0000, 4'b0000, 20'h0, '0);
    drive_instr(1, 2, 7, 32'h5, 32'h6, 32'h400, 0, 0, 0, 16'h0F0F);
    i_flush = 1;
    i_valid = 1;
    tick();
    settle();
    chk("fl_valid", o_valid, 0);
    chk("fl_rd", o_rd, 0);
    chk("fl_ctrl", o_ctrl, 0);
    chk("fl_ready", o_ready, 1);
    tick();
    i_flush = 0;
    i_valid = 0;
    settle();
    chk("fl_noload", o_valid, 0);
    chk("fl_cnt_kept", o_stall_cnt, 3);

    // Reset in the middle of a stall.
    do_reset();
    load_stall(6, 16'h0055);
    for (int t = 0; t < 5; t++) tick();
    chk("rs_cnt5", o_stall_cnt, 5);
    chk("rs_ready_stalled", o_ready, 0);
    i_reset_n = 0;
    tick();
    i_reset_n = 1;
    settle();
    chk("rs_valid", o_valid, 0);
    chk("rs_ready", o_ready, 1);
    chk("rs_cnt", o_stall_cnt, 0);
    chk("rs_ctrl", o_ctrl, 0);

    // Saturation of the 4-bit counter.
    do_reset();
    load_stall(2, 16'h0001);
    for (int t = 0; t < 14; t++) tick();
    chk("sat_cnt14", o_stall_cnt, 14);
    for (int t = 0; t < 6; t++) tick();
    chk("sat_cnt15", o_stall_cnt, 15);

    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
